// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the single CPU memory bus between instruction
// fetch (A) and load/store (B); the grant is held until the downstream acks.
package execute;
  typedef struct packed {
    logic       read;
    logic       write;
    logic [1:0] size;
    logic [7:0] byte_en;
  } memory_access_t;
endpackage

module bus_arbiter #(
  parameter int unsigned PLEN       = 33,
  parameter int unsigned XLEN       = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          a_cycle,
  input  logic [PLEN-1:0]               a_paddr,
  input  execute::memory_access_t       a_access,
  input  logic [XLEN-1:0]               a_data_out,
  output logic [LINE_WORDS*XLEN-1:0]    a_data_in,
  output logic                          a_ack,
  input  logic                          b_cycle,
  input  logic [PLEN-1:0]               b_paddr,
  input  execute::memory_access_t       b_access,
  input  logic [XLEN-1:0]               b_data_out,
  output logic [LINE_WORDS*XLEN-1:0]    b_data_in,
  output logic                          b_ack,
  output logic                          mem_cycle,
  output logic [PLEN-1:0]               mem_paddr,
  output execute::memory_access_t       mem_access,
  output logic [XLEN-1:0]               mem_data_out,
  input  logic [LINE_WORDS*XLEN-1:0]    mem_data_in,
  input  logic                          mem_ack,
  output logic [1:0]                    grant
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  state_t state;
  owner_t last_owner;
  logic   own_a;
  logic   own_b;

  // Ownership FSM; last_owner only moves on a completed transfer, so aborts
  // leave the round-robin pointer where it was.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= OWNER_B;
    end else begin
      case (state)
        IDLE: begin
          if (a_cycle && b_cycle) begin
            state <= (last_owner == OWNER_A) ? OWN_B : OWN_A;
          end else if (a_cycle) begin
            state <= OWN_A;
          end else if (b_cycle) begin
            state <= OWN_B;
          end
        end
        OWN_A: begin
          if (mem_ack) begin
            last_owner <= OWNER_A;
            state      <= b_cycle ? OWN_B : IDLE;
          end else if (!a_cycle) begin
            state <= IDLE;
          end
        end
        OWN_B: begin
          if (mem_ack) begin
            last_owner <= OWNER_B;
            state      <= a_cycle ? OWN_A : IDLE;
          end else if (!b_cycle) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign own_a = (state == OWN_A);
  assign own_b = (state == OWN_B);
  assign grant = state;

  // Downstream request mux; the bus is quiet while idle.
  always_comb begin
    mem_cycle    = 1'b0;
    mem_paddr    = '0;
    mem_access   = '0;
    mem_data_out = '0;
    if (own_a) begin
      mem_cycle    = a_cycle;
      mem_paddr    = a_paddr;
      mem_access   = a_access;
      mem_data_out = a_data_out;
    end else if (own_b) begin
      mem_cycle    = b_cycle;
      mem_paddr    = b_paddr;
      mem_access   = b_access;
      mem_data_out = b_data_out;
    end
  end

  assign a_ack     = own_a & mem_ack;
  assign b_ack     = own_b & mem_ack;
  assign a_data_in = mem_data_in;
  assign b_data_in = mem_data_in;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected acks are queued as stimulus is
// driven and retired by a monitor whenever the DUT acknowledges a transfer.
module tb_bus_arbiter;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    a_cycle, b_cycle;
  logic [32:0]             a_paddr, b_paddr;
  execute::memory_access_t a_access, b_access;
  logic [63:0]             a_data_out, b_data_out;
  logic [255:0]            a_data_in, b_data_in;
  logic                    a_ack, b_ack;
  logic                    mem_cycle;
  logic [32:0]             mem_paddr;
  execute::memory_access_t mem_access;
  logic [63:0]             mem_data_out;
  logic [255:0]            mem_data_in;
  logic                    mem_ack;
  logic [1:0]              grant;

  bus_arbiter dut (
    .clk(clk), .reset(reset),
    .a_cycle(a_cycle), .a_paddr(a_paddr), .a_access(a_access),
    .a_data_out(a_data_out), .a_data_in(a_data_in), .a_ack(a_ack),
    .b_cycle(b_cycle), .b_paddr(b_paddr), .b_access(b_access),
    .b_data_out(b_data_out), .b_data_in(b_data_in), .b_ack(b_ack),
    .mem_cycle(mem_cycle), .mem_paddr(mem_paddr), .mem_access(mem_access),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .mem_ack(mem_ack),
    .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   owner;
    logic [32:0]  paddr;
    logic [255:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   count_a  = 0;
  int   count_b  = 0;

  localparam logic [32:0] ADDR_A = 33'h0_0000_1000;
  localparam logic [32:0] ADDR_B = 33'h1_0000_0040;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] owner, input logic [255:0] data);
    exp_t e;
    e.owner = owner;
    e.paddr = (owner == 2'b01) ? ADDR_A : ADDR_B;
    e.data  = data;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    a_cycle = 1'b0;
    b_cycle = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 256'(grant), 256'(2'b00));
    check("rst_mem_cycle", 256'(mem_cycle), 256'(1'b0));
    check("rst_acks", 256'({b_ack, a_ack}), 256'(2'b00));
    reset = 1'b0;
  endtask

  // Retire one scoreboard entry per observed ack.
  always @(posedge clk) begin
    #2;
    if (a_ack || b_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 256'({b_ack, a_ack}), 256'(2'b00));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_owner", 256'({b_ack, a_ack}), 256'(e.owner));
        check("ack_paddr", 256'(mem_paddr), 256'(e.paddr));
        check("ack_data", a_ack ? a_data_in : b_data_in, e.data);
        if (a_ack) count_a++;
        if (b_ack) count_b++;
      end
    end
  end

  initial begin
    logic [255:0] d;
    logic [1:0]   prev;
    int           age;
    int           n;
    logic         next_a;

    a_paddr     = ADDR_A;
    b_paddr     = ADDR_B;
    a_access    = '{read: 1'b1, write: 1'b0, size: 2'b11, byte_en: 8'hff};
    b_access    = '{read: 1'b0, write: 1'b1, size: 2'b10, byte_en: 8'h0f};
    a_data_out  = 64'hA5A5_0000_1111_2222;
    b_data_out  = 64'h5A5A_3333_4444_5555;
    mem_data_in = '0;

    // A alone: one arbitration cycle, grant held until ack.
    do_reset();
    a_cycle = 1'b1;
    #1 check("a_only_arb_grant", 256'(grant), 256'(2'b00));
    check("a_only_arb_cycle", 256'(mem_cycle), 256'(1'b0));
    step(); #1;
    check("a_only_grant", 256'(grant), 256'(2'b01));
    check("a_only_cycle", 256'(mem_cycle), 256'(1'b1));
    check("a_only_paddr", 256'(mem_paddr), 256'(ADDR_A));
    check("a_only_access", 256'(mem_access), 256'(a_access));
    check("a_only_wdata", 256'(mem_data_out), 256'(a_data_out));
    step(); #1;
    check("a_only_hold", 256'(grant), 256'(2'b01));
    step();
    d = rnd256(); mem_data_in = d; mem_ack = 1'b1; push(2'b01, d);
    #1 check("a_only_b_ack", 256'(b_ack), 256'(1'b0));
    step();
    mem_ack = 1'b0; a_cycle = 1'b0;
    #1 check("a_only_idle", 256'(grant), 256'(2'b00));

    // Tie after reset goes to A, then B back-to-back.
    do_reset();
    a_cycle = 1'b1; b_cycle = 1'b1;
    step(); #1;
    check("tie_first", 256'(grant), 256'(2'b01));
    check("tie_paddr_a", 256'(mem_paddr), 256'(ADDR_A));
    step();
    d = rnd256(); mem_data_in = d; mem_ack = 1'b1; push(2'b01, d);
    step();
    mem_ack = 1'b0; a_cycle = 1'b0;
    #1 check("tie_b2b", 256'(grant), 256'(2'b10));
    check("tie_paddr_b", 256'(mem_paddr), 256'(ADDR_B));
    check("tie_access_b", 256'(mem_access), 256'(b_access));
    check("tie_cycle_b", 256'(mem_cycle), 256'(1'b1));
    step();
    d = rnd256(); mem_data_in = d; mem_ack = 1'b1; push(2'b10, d);
    step();
    mem_ack = 1'b0; b_cycle = 1'b0;
    #1 check("tie_idle", 256'(grant), 256'(2'b00));

    // Both re-requesting forever: grants must alternate, 4/4 over 8 transfers.
    count_a = 0; count_b = 0;
    prev = 2'b00; age = 0; n = 0; next_a = 1'b1;
    for (int cyc = 0; cyc < 100 && n < 8; cyc++) begin
      step();
      mem_ack = 1'b0; a_cycle = 1'b1; b_cycle = 1'b1;
      if (grant != prev) age = 0;
      else age++;
      prev = grant;
      if (grant != 2'b00 && age == 1) begin
        d = rnd256(); mem_data_in = d; mem_ack = 1'b1;
        push(next_a ? 2'b01 : 2'b10, d);
        next_a = ~next_a;
        n++;
      end
    end
    check("rr_transfers", 256'(n), 256'(8));
    step();
    mem_ack = 1'b0; a_cycle = 1'b0; b_cycle = 1'b0;
    check("rr_count_a", 256'(count_a), 256'(4));
    check("rr_count_b", 256'(count_b), 256'(4));
    step(); #1;
    check("rr_drop_idle", 256'(grant), 256'(2'b00));

    // Abort by B leaves last_owner at B, so the next tie still goes to A.
    do_reset();
    b_cycle = 1'b1;
    step(); #1;
    check("abort_own_b", 256'(grant), 256'(2'b10));
    step();
    b_cycle = 1'b0;
    #1 check("abort_cycle_low", 256'(mem_cycle), 256'(1'b0));
    check("abort_no_ack", 256'(b_ack), 256'(1'b0));
    step();
    a_cycle = 1'b1; b_cycle = 1'b1;
    #1 check("abort_idle", 256'(grant), 256'(2'b00));
    step(); #1;
    check("abort_tie_a", 256'(grant), 256'(2'b01));
    step();
    d = rnd256(); mem_data_in = d; mem_ack = 1'b1; push(2'b01, d);
    step();
    mem_ack = 1'b0; a_cycle = 1'b0; b_cycle = 1'b0;
    #1 check("abort_then_b", 256'(grant), 256'(2'b10));
    step(); #1;
    check("abort_b_drop", 256'(grant), 256'(2'b00));

    // Spurious ack while idle is ignored.
    step();
    mem_ack = 1'b1;
    #1 check("spur_acks", 256'({b_ack, a_ack}), 256'(2'b00));
    step();
    mem_ack = 1'b0;
    #1 check("spur_idle", 256'(grant), 256'(2'b00));

    // Asynchronous reset in the middle of an A transfer drops the ack.
    a_cycle = 1'b1;
    step(); #1;
    check("midrst_own", 256'(grant), 256'(2'b01));
    check("midrst_cycle", 256'(mem_cycle), 256'(1'b1));
    step();
    #2;
    mem_ack = 1'b1; reset = 1'b1;
    #1 check("midrst_cycle_low", 256'(mem_cycle), 256'(1'b0));
    check("midrst_grant", 256'(grant), 256'(2'b00));
    check("midrst_acks", 256'({b_ack, a_ack}), 256'(2'b00));
    step();
    mem_ack = 1'b0; reset = 1'b0;
    #1 check("midrst_release", 256'(grant), 256'(2'b00));
    step(); #1;
    check("midrst_regrant", 256'(grant), 256'(2'b01));
    step();
    d = rnd256(); mem_data_in = d; mem_ack = 1'b1; push(2'b01, d);
    step();
    mem_ack = 1'b0; a_cycle = 1'b0;
    step(); #1;
    check("final_idle", 256'(grant), 256'(2'b00));
    check("sb_drained", 256'(sb.size()), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
